// File: rtl/k007452_pkg.sv
`default_nettype none
// ============================================================================
// k007452_pkg : register map, FSM state encoding and STATUS bit positions
//               shared by the 007452 DMP multiply/divide sequencer
// Rev 1.0
// ============================================================================
package k007452_pkg;

  // write offsets
  localparam logic [2:0] DMP_MA   = 3'd0;
  localparam logic [2:0] DMP_MB   = 3'd1;
  localparam logic [2:0] DMP_DVDL = 3'd2;
  localparam logic [2:0] DMP_DVDH = 3'd3;
  localparam logic [2:0] DMP_DVSL = 3'd4;
  localparam logic [2:0] DMP_DVSH = 3'd5;

  // read offsets
  localparam logic [2:0] DMP_RD_RES0L  = 3'd0;
  localparam logic [2:0] DMP_RD_RES0H  = 3'd1;
  localparam logic [2:0] DMP_RD_RES1L  = 3'd2;
  localparam logic [2:0] DMP_RD_RES1H  = 3'd3;
  localparam logic [2:0] DMP_RD_STATUS = 3'd4;

  localparam int STAT_BUSY   = 7;
  localparam int STAT_DIV0   = 6;
  localparam int STAT_LASTOP = 5;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } dmp_state_e;

endpackage
`default_nettype wire

// File: rtl/k007452_muldiv_core.sv
`default_nettype none
// ============================================================================
// k007452_muldiv_core : working registers and single-step shift-add multiply /
//                       restoring divide datapath
// Rev 1.0
// ============================================================================
module k007452_muldiv_core
  import k007452_pkg::*;
#(
  parameter int MUL_W = 8,
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 op,
  input  logic                 step,
  input  logic [MUL_W-1:0]     mcand_in,
  input  logic [MUL_W-1:0]     mplr_in,
  input  logic [DIV_W-1:0]     dvd_in,
  input  logic [DIV_W-1:0]     dvs_in,
  output logic [2*MUL_W-1:0]   prod,
  output logic [DIV_W-1:0]     quot,
  output logic [DIV_W-1:0]     rem
);

  // acc holds {partial product high half, remaining multiplier bits}
  logic [2*MUL_W-1:0] acc_q, acc_d;
  logic [MUL_W-1:0]   mcand_q, mcand_d;
  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [DIV_W-1:0]   dvs_q, dvs_d;
  logic [DIV_W-1:0]   rem_q, rem_d;

  logic [MUL_W:0]     mul_sum;
  logic [DIV_W-1:0]   rem_sh;
  logic [DIV_W-1:0]   rem_sub;
  logic               rem_ge;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;

    mul_sum = {1'b0, acc_q[2*MUL_W-1:MUL_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // rem_q[DIV_W-1] is the bit shifted out; when set the shifted value exceeds any divisor
    rem_sh  = {rem_q[DIV_W-2:0], dvd_q[DIV_W-1]};
    rem_ge  = rem_q[DIV_W-1] | (rem_sh >= dvs_q);
    rem_sub = rem_sh - dvs_q;

    if (load) begin
      acc_d   = {{MUL_W{1'b0}}, mplr_in};
      mcand_d = mcand_in;
      dvd_d   = dvd_in;
      dvs_d   = dvs_in;
      rem_d   = '0;
    end else if (step) begin
      if (op == OP_MUL) begin
        acc_d = {mul_sum, acc_q[MUL_W-1:1]};
      end else begin
        dvd_d = {dvd_q[DIV_W-2:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_sh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
    end
  end

  assign prod = acc_q;
  assign quot = dvd_q;
  assign rem  = rem_q;

endmodule
`default_nettype wire

// File: rtl/k007452_muldiv_seq.sv
`default_nettype none
// ============================================================================
// k007452_muldiv_seq : CPU register front-end and step sequencer for the
//                      007452 DMP multiply/divide datapath
// Rev 1.0
// ============================================================================
module k007452_muldiv_seq
  import k007452_pkg::*;
#(
  parameter int MUL_W    = 8,
  parameter int DIV_W    = 16,
  parameter int PRESCALE = 4
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  input  logic [2:0] AB,
  input  logic [7:0] DB_IN,
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  output logic       BUSY,
  output logic       DONE
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_W - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_W - 1);

  dmp_state_e        state_q, state_d;
  logic              wr_prev_q, wr_prev_d;
  logic [MUL_W-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic [DIV_W-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  res0_q, res0_d, res1_q, res1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
  logic              lastop_q, lastop_d;

  logic              wr_now, wr_rise;
  logic              start, start_op;
  logic              core_load, core_step, core_op;
  logic [2*MUL_W-1:0] prod;
  logic [DIV_W-1:0]  quot, rem;
  logic [7:0]        status, rd_data;

  always_comb begin
    wr_now    = CS & WR;
    wr_rise   = wr_now & ~wr_prev_q;
    wr_prev_d = wr_now;

    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    res0_d    = res0_q;
    res1_d    = res1_q;
    done_d    = 1'b0;
    div0_d    = div0_q;
    lastop_d  = lastop_q;
    core_load = 1'b0;
    core_step = 1'b0;
    start     = 1'b0;
    start_op  = OP_MUL;

    if (wr_rise) begin
      case (AB)
        DMP_MA:   ma_d = DB_IN[MUL_W-1:0];
        DMP_MB: begin
          mb_d     = DB_IN[MUL_W-1:0];
          start    = 1'b1;
          start_op = OP_MUL;
        end
        DMP_DVDL: dvd_d = {dvd_q[DIV_W-1:8], DB_IN};
        DMP_DVDH: dvd_d = {DB_IN, dvd_q[7:0]};
        DMP_DVSL: dvs_d = {dvs_q[DIV_W-1:8], DB_IN};
        DMP_DVSH: begin
          dvs_d    = {DB_IN, dvs_q[7:0]};
          start    = 1'b1;
          start_op = OP_DIV;
        end
        default: ;
      endcase
    end

    // a start always wins over the running op: it reloads the core and suppresses any result write
    if (start) begin
      state_d   = (start_op == OP_DIV) ? DIV : MUL;
      pre_d     = '0;
      cnt_d     = '0;
      core_load = 1'b1;
      lastop_d  = start_op;
      div0_d    = (start_op == OP_DIV) && (dvs_d == '0);
    end else begin
      case (state_q)
        MUL, DIV: begin
          if (pre_q == PRE_LAST) begin
            core_step = 1'b1;
            pre_d     = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == ((state_q == DIV) ? DIV_LAST : MUL_LAST))
              state_d = FIN;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        FIN: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (lastop_q == OP_DIV) begin
            res0_d = quot;
            res1_d = rem;
          end else begin
            res0_d = DIV_W'(prod);
          end
        end
        default: ;
      endcase
    end

    // BUSY lags the state by one edge so it falls together with the result write
    busy_d = (state_q == MUL) || (state_q == DIV) || (start && busy_q);
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q   <= IDLE;
      wr_prev_q <= 1'b0;
      ma_q      <= '0;
      mb_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      lastop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_prev_q <= wr_prev_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      lastop_q  <= lastop_d;
    end
  end

  assign core_op = (state_q == DIV) ? OP_DIV : OP_MUL;

  k007452_muldiv_core #(
    .MUL_W (MUL_W),
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RES),
    .load     (core_load),
    .op       (core_op),
    .step     (core_step),
    .mcand_in (ma_d),
    .mplr_in  (mb_d),
    .dvd_in   (dvd_d),
    .dvs_in   (dvs_d),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem)
  );

  always_comb begin
    status              = 8'h00;
    status[STAT_BUSY]   = busy_q;
    status[STAT_DIV0]   = div0_q;
    status[STAT_LASTOP] = lastop_q;
  end

  always_comb begin
    rd_data = 8'h00;
    case (AB)
      DMP_RD_RES0L:  rd_data = res0_q[7:0];
      DMP_RD_RES0H:  rd_data = res0_q[15:8];
      DMP_RD_RES1L:  rd_data = res1_q[7:0];
      DMP_RD_RES1H:  rd_data = res1_q[15:8];
      DMP_RD_STATUS: rd_data = status;
      default: ;
    endcase
  end

  assign DB_OE  = CS & RD;
  assign DB_OUT = DB_OE ? rd_data : 8'h00;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_k007452_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_k007452_muldiv_seq : scoreboard bench for the DMP multiply/divide sequencer
// Rev 1.0
// ============================================================================
module tb_k007452_muldiv_seq;

  localparam int PRESCALE = 4;
  localparam int MUL_BUSY = 8 * PRESCALE;
  localparam int DIV_BUSY = 16 * PRESCALE;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0] ab = 3'd0;
  logic [7:0] db_in = 8'h00;
  logic [7:0] db_out;
  logic       db_oe, busy, done;

  typedef struct {
    logic [15:0] res0;
    logic [15:0] res1;
    logic [7:0]  status;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_res0, m_res1;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  k007452_muldiv_seq #(
    .MUL_W    (8),
    .DIV_W    (16),
    .PRESCALE (PRESCALE)
  ) dut (
    .CLK    (clk),
    .RES    (res_n),
    .CS     (cs),
    .WR     (wr),
    .RD     (rd),
    .AB     (ab),
    .DB_IN  (db_in),
    .DB_OUT (db_out),
    .DB_OE  (db_oe),
    .BUSY   (busy),
    .DONE   (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; ab = a; db_in = d;
    repeat (hold) @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; ab = a;
    #1 d = db_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic read16(input logic [2:0] a_lo, output logic [15:0] v);
    logic [7:0] b0, b1;
    bus_read(a_lo, b0);
    bus_read(a_lo + 3'd1, b1);
    v = {b1, b0};
  endtask

  task automatic push_mul(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.res0   = {8'h00, a} * {8'h00, b};
    e.res1   = m_res1;
    e.status = 8'h00;
    e.busy   = MUL_BUSY;
    sb.push_back(e);
  endtask

  task automatic push_div(input logic [15:0] n, input logic [15:0] d);
    exp_t e;
    e.res0   = (d == 16'h0) ? 16'hFFFF : n / d;
    e.res1   = (d == 16'h0) ? n : n % d;
    e.status = {1'b0, (d == 16'h0), 1'b1, 5'b0};
    e.busy   = DIV_BUSY;
    sb.push_back(e);
  endtask

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b);
    bus_write(3'd0, a, 1);
    bus_write(3'd1, b, 1);
    push_mul(a, b);
  endtask

  task automatic run_div(input logic [15:0] n, input logic [15:0] d);
    bus_write(3'd2, n[7:0], 1);
    bus_write(3'd3, n[15:8], 1);
    bus_write(3'd4, d[7:0], 1);
    bus_write(3'd5, d[15:8], 1);
    push_div(n, d);
  endtask

  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic finish_op(input string tag);
    int          busy_n;
    bit          seen;
    exp_t        e;
    logic [15:0] r0, r1;
    logic [7:0]  st;
    wait_done(busy_n, seen);
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!seen) return;
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(e.busy));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    read16(3'd0, r0);
    read16(3'd2, r1);
    bus_read(3'd4, st);
    chk({tag, ".res0"}, 32'(r0), 32'(e.res0));
    chk({tag, ".res1"}, 32'(r1), 32'(e.res1));
    chk({tag, ".status"}, 32'(st), 32'(e.status));
    m_res0 = e.res0;
    m_res1 = e.res1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  b;
    int          n_done;
    m_res0 = 16'h0;
    m_res1 = 16'h0;

    repeat (3) @(negedge clk);
    res_n = 1'b1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("idle.db_oe", 32'(db_oe), 32'd0);
    chk("idle.db_out", 32'(db_out), 32'd0);
    read16(3'd0, v); chk("rst.res0", 32'(v), 32'd0);
    read16(3'd2, v); chk("rst.res1", 32'(v), 32'd0);
    bus_read(3'd4, b); chk("rst.status", 32'(b), 32'd0);
    bus_read(3'd6, b); chk("rd.unused", 32'(b), 32'd0);

    run_mul(8'h0C, 8'h0B);      finish_op("mul_0c_0b");
    run_div(16'h1234, 16'h0010); finish_op("div_1234_10");
    run_mul(8'hFF, 8'hFF);      finish_op("mul_ff_ff");
    run_div(16'hBEEF, 16'h0000); finish_op("div_by_zero");

    for (int i = 0; i < 3; i++) begin
      run_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      finish_op("mul_rand");
      run_div(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 300)));
      finish_op("div_rand");
    end

    // restart mid-op: first multiply must never complete
    bus_write(3'd0, 8'h03, 1);
    bus_write(3'd1, 8'h05, 1);
    push_mul(8'h03, 8'h05);
    repeat (8) @(negedge clk);
    read16(3'd0, v);   chk("busy.res0_prev", 32'(v), 32'(m_res0));
    bus_read(3'd4, b); chk("busy.status", 32'(b), 32'h80);
    bus_write(3'd1, 8'h02, 1);
    void'(sb.pop_back());
    push_mul(8'h03, 8'h02);
    finish_op("abort_restart");

    // long strobe gives a single start at its rising edge
    bus_write(3'd1, 8'h07, 5);
    push_mul(8'h03, 8'h07);
    sb[sb.size() - 1].busy = MUL_BUSY - 4;
    finish_op("long_strobe");

    // reset in the middle of an operation
    run_mul(8'h21, 8'h13);
    repeat (20) @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    void'(sb.pop_back());
    m_res0 = 16'h0;
    m_res1 = 16'h0;
    chk("midrst.busy", 32'(busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst.no_done", 32'(n_done), 32'd0);
    read16(3'd0, v);   chk("midrst.res0", 32'(v), 32'd0);
    read16(3'd2, v);   chk("midrst.res1", 32'(v), 32'd0);
    bus_read(3'd4, b); chk("midrst.status", 32'(b), 32'd0);

    run_mul(8'h0C, 8'h0B); finish_op("mul_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
